ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port synchronous RAM: 16-bit data, 12-bit address, 4096 words, 1-cycle registered read, write on the load pulse.
- Shares the RAM between a capture port (A) and a playback port (B) using valid/ready handshakes and round-robin priority.
- Routes read data back to the requester that issued the read.
- Optionally clears the whole RAM after reset before any requester is served.

Parameters:
- DWIDTH, 16, data word width.
- AWIDTH, 12, address width.
- WORDS, 4096, number of RAM words; also the clear-sequence length.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request valid; held until granted.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  AWIDTH  port A address.
- a_wdata  in  DWIDTH  port A write data.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DWIDTH  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_load  out  1  RAM write enable.
- ram_addr  out  AWIDTH  RAM address.
- ram_d  out  DWIDTH  RAM write data.
- ram_q  in  DWIDTH  RAM registered read data.
- init_done  out  1  arbiter is serving requests.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assert, active-low, synchronous-release use.
- Reset values: state = INIT (macro defined) or ARB (macro undefined); last_gnt = B, so A wins the first contention; rd_pending = 0; clear counter = 0.
- Output values during and after reset: all gnt = 0, all rvalid = 0, ram_load = 0.
- FSM state INIT:
  - ram_load = 1, ram_addr = counter, ram_d = 0.
  - counter increments each cycle.
  - At counter == WORDS-1, go to ARB next cycle.
  - No grants in INIT; init_done = 0.
- FSM state ARB: init_done = 1. Stays in ARB until reset.
- Grant rules (combinational, ARB only):
  - Only A requesting -> a_gnt.
  - Only B requesting -> b_gnt.
  - Both requesting -> grant the port that is not last_gnt.
  - At most one gnt per cycle.
  - last_gnt updates on every grant.
- RAM mux:
  - ram_addr and ram_d come from the granted port.
  - ram_load = granted port's we.
  - With no grant: ram_load = 0, ram_addr holds the last granted address.
- Handshake:
  - A transfer occurs when req and gnt are both high at the rising edge.
  - The requester keeps req, we, addr and wdata stable until gnt.
  - Back-to-back grants to the same port are allowed when the other port is idle.
- Read return:
  - On a read grant, register rd_pending = 1 and rd_owner = granted port.
  - Next cycle: owner's rvalid = 1 and its rdata = ram_q.
  - rdata of the non-owner port holds ram_q but its rvalid = 0.
  - Fixed read latency: exactly 1 cycle after the gnt edge.
  - Reads may issue every cycle.
- Write then read, same address, consecutive grants: the read returns the new data.
- Write grants never assert rvalid.
- Reset mid-operation: the pending read is discarded (no rvalid), the FSM restarts per the macro, and an in-progress clear restarts from address 0.

Optional Feature:
- Macro: RAM_ARB_INIT_EN.
- Defined: INIT state is present; the RAM is zeroed over WORDS cycles after every reset; init_done rises after the last clear write.
- Undefined: INIT logic and the clear counter are removed; the FSM resets directly into ARB; init_done = 1 from the first cycle after reset release; RAM contents are undefined.

Test Plan:
- Reset with RAM_ARB_INIT_EN -> ram_load high for exactly 4096 cycles at addresses 0..4095 with ram_d = 0, then init_done = 1; a read of 0x123 returns 0x0000.
- A writes 0xBEEF to 0x010; the next cycle A reads 0x010 -> a_rvalid pulses one cycle after the read gnt with a_rdata = 0xBEEF; b_rvalid stays 0.
- a_req and b_req both held high for 6 cycles -> grants alternate A, B, A, B, A, B.
- B issues 4 consecutive reads at 0x000..0x003 with A idle -> b_gnt held for 4 cycles; b_rvalid on 4 consecutive cycles with the matching data.
- Assert rst_n low in the cycle after a read grant -> no rvalid; outputs reset; with the macro defined, the clear restarts at address 0.
- Macro undefined -> init_done = 1 in the first cycle after reset release; a request is granted immediately.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter and sequencer for a single-port synchronous RAM
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata        port A request (held until a_gnt)
//   a_gnt/a_rvalid/a_rdata           port A accept, read-data valid, read data
//   b_*                              same as port A, for port B
//   ram_load/ram_addr/ram_d/ram_q    RAM write enable, address, write data, registered read data
//   init_done                        high while requests are being served
// Define RAM_ARB_INIT_EN to zero the whole RAM after every reset before serving requests.
module ram_arbiter #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int WORDS  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DWIDTH-1:0] b_rdata,
  output logic              ram_load,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_d,
  input  logic [DWIDTH-1:0] ram_q,
  output logic              init_done
);
  localparam logic [0:0] ARB = 1'b1;
  if (WORDS > (1 << AWIDTH)) begin : g_bad_words
    $error("WORDS exceeds the address space");
  end
  logic              state;
  logic              clr;
  logic              last_gnt;
  logic              rd_pending;
  logic              rd_owner;
  logic [AWIDTH-1:0] addr_q;
  logic              arb;
  logic              a_win;
  logic              gnt;
  logic              we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_d;
`ifdef RAM_ARB_INIT_EN
  localparam logic [0:0] INIT = 1'b0;
  localparam int CW = $clog2(WORDS);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WORDS - 1)) state <= ARB;
    end
  end
  assign clr = rst_n && state == INIT;
  always_comb begin
    ram_addr = clr ? AWIDTH'(cnt) : sel_addr;
    ram_d    = clr ? '0 : sel_d;
  end
`else
  assign state    = ARB;
  assign clr      = 1'b0;
  assign ram_addr = sel_addr;
  assign ram_d    = sel_d;
`endif
  // Gating with rst_n keeps every strobe low while reset is held.
  assign arb   = rst_n && state == ARB;
  // A wins when alone, or on contention when B was granted last.
  assign a_win = a_req && (!b_req || last_gnt);
  assign a_gnt = arb && a_win;
  assign b_gnt = arb && b_req && !a_win;
  assign gnt   = a_gnt || b_gnt;
  assign we    = b_gnt ? b_we : a_we;
  always_comb begin
    sel_addr = b_gnt ? b_addr : a_gnt ? a_addr : addr_q;
    sel_d    = b_gnt ? b_wdata : a_gnt ? a_wdata : '0;
  end
  assign ram_load  = clr || (gnt && we);
  assign init_done = state == ARB;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt   <= 1'b1;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      addr_q     <= '0;
    end else begin
      rd_pending <= gnt && !we;
      if (gnt) begin
        last_gnt <= b_gnt;
        rd_owner <= b_gnt;
        addr_q   <= sel_addr;
      end
    end
  end
  assign a_rvalid = rd_pending && !rd_owner;
  assign b_rvalid = rd_pending && rd_owner;
  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [11:0] a_addr = '0, b_addr = '0, ram_addr;
  logic [15:0] a_wdata = '0, b_wdata = '0, a_rdata, b_rdata, ram_d, ram_q;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_load, init_done;
  logic [15:0] mem [4096];
  int          n_chk = 0;
  int          n_pass = 0;
  always #5 clk = ~clk;
  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_load(ram_load), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q),
    .init_done(init_done)
  );
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  initial begin
    int a_k, b_k, n;
    bit bad, exp_a;
    for (int i = 0; i < 4096; i++) mem[i] = 16'hDEAD ^ 16'(i);
    a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_ram_load", ram_load, 0);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0; rst_n = 1'b1;
    #1;
`ifdef RAM_ARB_INIT_EN
    chk("init_done_low", init_done, 0);
    n = 0; bad = 1'b0;
    for (int i = 0; i < 5000 && !init_done; i++) begin
      if (ram_load) begin
        if (ram_addr !== 12'(n) || ram_d !== 16'h0) bad = 1'b1;
        n++;
      end
      @(negedge clk); #1;
    end
    chk("clear_cycles", n, 4096);
    chk("clear_addr_data", bad, 0);
    chk("init_done_high", init_done, 1);
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h123;
    #1 chk("rd123_gnt", a_gnt, 1);
    @(negedge clk); a_req = 1'b0;
    #1 chk("rd123_rvalid", a_rvalid, 1);
    chk("rd123_rdata", a_rdata, 16'h0000);
`else
    chk("init_done_now", init_done, 1);
`endif
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h010; a_wdata = 16'hBEEF;
    #1;
    chk("wr_a_gnt", a_gnt, 1);
    chk("wr_b_gnt", b_gnt, 0);
    chk("wr_load", ram_load, 1);
    chk("wr_addr", ram_addr, 12'h010);
    chk("wr_d", ram_d, 16'hBEEF);
    @(negedge clk); a_we = 1'b0;
    #1;
    chk("rd_a_gnt", a_gnt, 1);
    chk("rd_load", ram_load, 0);
    chk("wr_no_rvalid", a_rvalid, 0);
    @(negedge clk); a_req = 1'b0;
    #1;
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 16'hBEEF);
    chk("rd_b_rvalid", b_rvalid, 0);
    chk("idle_addr_hold", ram_addr, 12'h010);
    chk("idle_load", ram_load, 0);
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h7FF; b_wdata = 16'h1234;
    #1;
    chk("a_rvalid_pulse", a_rvalid, 0);
    chk("bw_gnt", b_gnt, 1);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_k = 0; b_k = 0;
    for (int i = 0; i < 6; i++) begin
      a_addr = 12'(2 * a_k); a_wdata = 16'hC000 + 16'(2 * a_k);
      b_addr = 12'(2 * b_k + 1); b_wdata = 16'hC000 + 16'(2 * b_k + 1);
      exp_a = (i % 2) == 0;
      #1;
      if (i == 0) chk("bw_no_rvalid", b_rvalid, 0);
      chk($sformatf("alt%0d_a_gnt", i), a_gnt, 32'(exp_a));
      chk($sformatf("alt%0d_b_gnt", i), b_gnt, 32'(!exp_a));
      chk($sformatf("alt%0d_addr", i), ram_addr, exp_a ? 2 * a_k : 2 * b_k + 1);
      if (exp_a) a_k++;
      else b_k++;
      @(negedge clk);
    end
    a_req = 1'b0; b_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_addr = 12'(i);
      #1;
      chk($sformatf("brd%0d_gnt", i), b_gnt, 1);
      if (i > 0) begin
        chk($sformatf("brd%0d_rvalid", i - 1), b_rvalid, 1);
        chk($sformatf("brd%0d_rdata", i - 1), b_rdata, 16'hC000 + 16'(i - 1));
      end
      chk($sformatf("brd%0d_a_rvalid", i), a_rvalid, 0);
      @(negedge clk);
    end
    b_req = 1'b0;
    #1;
    chk("brd3_rvalid", b_rvalid, 1);
    chk("brd3_rdata", b_rdata, 16'hC003);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h010;
    #1;
    chk("b_rvalid_end", b_rvalid, 0);
    chk("mid_rd_gnt", a_gnt, 1);
    @(negedge clk);
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b1; b_we = 1'b1;
    #1;
    chk("mid_rst_a_rvalid", a_rvalid, 0);
    chk("mid_rst_b_rvalid", b_rvalid, 0);
    chk("mid_rst_b_gnt", b_gnt, 0);
    chk("mid_rst_load", ram_load, 0);
    @(negedge clk); @(negedge clk);
    b_req = 1'b0; rst_n = 1'b1;
    #1;
    chk("post_rst_a_rvalid", a_rvalid, 0);
`ifdef RAM_ARB_INIT_EN
    chk("reclear_load", ram_load, 1);
    chk("reclear_addr0", ram_addr, 0);
    chk("reclear_init_done", init_done, 0);
    @(negedge clk); #1;
    chk("reclear_addr1", ram_addr, 1);
`endif
    for (int i = 0; i < 5000 && !init_done; i++) begin
      @(negedge clk); #1;
    end
    chk("post_rst_init_done", init_done, 1);
    a_req = 1'b1; a_we = 1'b0; b_req = 1'b1; b_we = 1'b0;
    #1;
    chk("post_rst_a_first", a_gnt, 1);
    chk("post_rst_b_wait", b_gnt, 0);
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
